am2940_ctrl: RTL and testbench
==============================

# am2940_ctrl

Control section of the Am2940 DMA address generator: decodes the 3-bit instruction, holds the control register and the word count logic, and drives the load/enable/direction/carry inputs of the cascaded 4-bit `counter` slices that form the address counter. It generates DONE and auto-reinitialisation for each transfer mode and returns readback data to the host bus. It sits directly upstream of the address counter slices and feeds them on every clock.

## Interface
- `WIDTH`, 8, word counter and data bus width.
- `clk`  in  1  clock, all state updates on rising edge.
- `res`  in  1  synchronous, active-low reset.
- `instr`  in  3  instruction code (see Operation).
- `instr_en`  in  1  execute `instr` this cycle.
- `data_in`  in  WIDTH  host data for WRCR / LDWC; LDAD data goes straight to the slices.
- `cnt_en`  in  1  transfer strobe; one transfer per high cycle.
- `addr_load`  out  1  load strobe to all address slices (combinational).
- `addr_reinit`  out  1  reload address slices from their initial register (combinational).
- `addr_enable`  out  1  count enable to all address slices (combinational).
- `addr_up`  out  1  direction to slices, 1 = increment (= ~ctrl[2]).
- `addr_carry_in`  out  1  carry_in of the low-order slice, equal to `addr_enable`.
- `ctrl_out`  out  3  control register.
- `wc_out`  out  WIDTH  word counter.
- `done`  out  1  terminal-count indication (combinational from registers).
- `data_out`  out  WIDTH  registered readback.
- `data_oe`  out  1  `data_out` valid, one-cycle pulse.

## Operation
- Registers: ctrl[2:0], wc, wc_init, cnt_ok, data_out, data_oe.
- Instructions, executed when `instr_en`=1:
  - 000 WRCR: ctrl <= data_in[2:0]; cnt_ok <= 0.
  - 001 RDCR: data_out <= zero-extended ctrl; data_oe <= 1.
  - 010 RDWC: data_out <= wc; data_oe <= 1.
  - 011 NOP.
  - 100 REINIT: wc <= (mode 01 ? 0 : wc_init); addr_reinit=1 this cycle; cnt_ok unchanged.
  - 101 LDAD: addr_load=1 this cycle.
  - 110 LDWC: wc_init <= data_in; wc <= (mode 01 ? 0 : data_in); cnt_ok <= 0.
  - 111 ENCT: cnt_ok <= 1.
- data_oe <= 0 on every cycle without RDCR/RDWC; data_out holds.
- Transfer = cnt_en & cnt_ok & ~instr_en. Drives addr_enable = addr_carry_in = 1. An instruction cycle always suppresses counting.
- Modes (ctrl[1:0]):
  - 00, decrement/stop: transfer wc <= wc-1; done = (wc==1); a transfer with done=1 also clears cnt_ok.
  - 01, increment/stop: transfer wc <= wc+1; done = (wc == wc_init-1, mod 2^WIDTH); a transfer with done=1 clears cnt_ok.
  - 10, decrement/auto-reinit: done = (wc==1); a transfer with done=1 loads wc <= wc_init and asserts addr_reinit instead of addr_enable; cnt_ok stays 1.
  - 11, free-run: wc frozen, done=0, transfers never stop.
- wc arithmetic wraps modulo 2^WIDTH. Decrementing from 0 gives all-ones.

## Timing
- Reset (res=0 at an edge): ctrl=0, wc=0, wc_init=0, cnt_ok=0, data_out=0, data_oe=0. Hence done=0, addr_up=1, and all strobes are 0 while instr_en/cnt_en are 0.
- Reset overrides any simultaneous instruction or transfer, and aborts a transfer sequence mid-count.
- addr_load, addr_reinit and addr_enable are combinational in the instruction/transfer cycle. The slices act on the same edge at which this block updates wc.
- Readback latency is 1 cycle: data_out and data_oe are valid the cycle after RDCR/RDWC.
- done reflects the post-edge register state, zero latency after the wc update.
- ENCT takes effect from the next cycle. A cnt_en in the ENCT cycle is ignored.

## Test plan
- Reset with instr_en=1, instr=111 -> cnt_ok, wc, ctrl stay 0; done=0; data_oe=0.
- Mode 00, ctrl=000: WRCR, LDWC 3, ENCT, then 4 cnt_en cycles -> wc 3,2,1,0; done high while wc=1; addr_enable high for exactly 3 cycles; wc stays 0 on the 4th.
- Mode 01: LDWC 4 -> wc=0; after ENCT, transfers give wc 1,2,3; done at wc=3; counting stops after the 4th transfer with wc=4.
- Mode 10, ctrl=110: LDWC 2, ENCT, 5 transfers -> wc 1, 2 (reload, addr_reinit pulse), 1, 2 (reload, addr_reinit pulse), 1; addr_up=0 throughout.
- RDWC with wc=0x5A -> data_out=0x5A and data_oe=1 one cycle later, for one cycle. cnt_en asserted during the RDWC cycle -> no transfer.
- LDAD with cnt_en=1 and cnt_ok=1 -> addr_load=1, addr_enable=0 in that cycle. Mode 11 -> wc unchanged and done=0 over 10 transfers.

Source files
------------

// File: rtl/am2940_ctrl_if.sv
// Host-side bus of the Am2940 control section.
// Host -> ctrl : instr, instr_en, data_in, cnt_en
// Ctrl -> slices: addr_load, addr_reinit, addr_enable, addr_up, addr_carry_in
// Ctrl -> host : ctrl_out, wc_out, done, data_out, data_oe
interface am2940_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [2:0]       instr;
  logic             instr_en;
  logic [WIDTH-1:0] data_in;
  logic             cnt_en;
  logic             addr_load;
  logic             addr_reinit;
  logic             addr_enable;
  logic             addr_up;
  logic             addr_carry_in;
  logic [2:0]       ctrl_out;
  logic [WIDTH-1:0] wc_out;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             data_oe;

  modport master (
    output instr, instr_en, data_in, cnt_en,
    input  addr_load, addr_reinit, addr_enable, addr_up, addr_carry_in,
    input  ctrl_out, wc_out, done, data_out, data_oe
  );

  modport slave (
    input  instr, instr_en, data_in, cnt_en,
    output addr_load, addr_reinit, addr_enable, addr_up, addr_carry_in,
    output ctrl_out, wc_out, done, data_out, data_oe
  );
endinterface

// File: rtl/am2940_ctrl.sv
// Am2940 DMA address generator control section.
// Decodes the 3-bit instruction, holds the control register, the word counter and its
// initial value, and drives load/reinit/enable/direction/carry to the address slices.
// Ports:
//   clk - clock, rising edge
//   res - synchronous active-low reset
//   bus - am2940_ctrl_if slave modport (instruction/data in, slice strobes and readback out)
module am2940_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          res,
  am2940_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    InstrWrcr   = 3'b000,
    InstrRdcr   = 3'b001,
    InstrRdwc   = 3'b010,
    InstrNop    = 3'b011,
    InstrReinit = 3'b100,
    InstrLdad   = 3'b101,
    InstrLdwc   = 3'b110,
    InstrEnct   = 3'b111
  } instr_e;

  localparam logic [WIDTH-1:0] WcOne = WIDTH'(1);

  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] wc_q, wc_d;
  logic [WIDTH-1:0] wc_init_q, wc_init_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             cnt_ok_q, cnt_ok_d;
  logic             data_oe_q, data_oe_d;

  logic [1:0] mode;
  logic       transfer;
  logic       done;
  logic       auto_reload;
  instr_e     instr;

  assign mode     = ctrl_q[1:0];
  assign instr    = instr_e'(bus.instr);
  // Any instruction cycle suppresses counting.
  assign transfer = bus.cnt_en & cnt_ok_q & ~bus.instr_en;

  // Terminal count is a function of registered state only.
  always_comb begin
    done = 1'b0;
    unique case (mode)
      2'b00, 2'b10: done = (wc_q == WcOne);
      2'b01:        done = (wc_q == wc_init_q - WcOne);
      default:      done = 1'b0;
    endcase
  end

  // Mode 10 terminal transfer reloads instead of counting.
  assign auto_reload = transfer & (mode == 2'b10) & done;

  // State register.
  always_ff @(posedge clk) begin
    if (!res) begin
      ctrl_q     <= '0;
      wc_q       <= '0;
      wc_init_q  <= '0;
      cnt_ok_q   <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      wc_q       <= wc_d;
      wc_init_q  <= wc_init_d;
      cnt_ok_q   <= cnt_ok_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  // Next-state logic.
  always_comb begin
    ctrl_d     = ctrl_q;
    wc_d       = wc_q;
    wc_init_d  = wc_init_q;
    cnt_ok_d   = cnt_ok_q;
    data_out_d = data_out_q;
    data_oe_d  = 1'b0;
    if (bus.instr_en) begin
      unique case (instr)
        InstrWrcr: begin
          ctrl_d   = bus.data_in[2:0];
          cnt_ok_d = 1'b0;
        end
        InstrRdcr: begin
          data_out_d = {{(WIDTH-3){1'b0}}, ctrl_q};
          data_oe_d  = 1'b1;
        end
        InstrRdwc: begin
          data_out_d = wc_q;
          data_oe_d  = 1'b1;
        end
        InstrReinit: wc_d = (mode == 2'b01) ? '0 : wc_init_q;
        InstrLdwc: begin
          wc_init_d = bus.data_in;
          wc_d      = (mode == 2'b01) ? '0 : bus.data_in;
          cnt_ok_d  = 1'b0;
        end
        InstrEnct: cnt_ok_d = 1'b1;
        default: ;  // NOP and LDAD leave this block's state alone
      endcase
    end else if (transfer) begin
      unique case (mode)
        2'b00: begin
          wc_d = wc_q - WcOne;
          if (done) cnt_ok_d = 1'b0;
        end
        2'b01: begin
          wc_d = wc_q + WcOne;
          if (done) cnt_ok_d = 1'b0;
        end
        2'b10:   wc_d = done ? wc_init_q : wc_q - WcOne;
        default: ;  // free-run: word counter frozen
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.addr_load     = bus.instr_en & (instr == InstrLdad);
    bus.addr_reinit   = (bus.instr_en & (instr == InstrReinit)) | auto_reload;
    bus.addr_enable   = transfer & ~auto_reload;
    bus.addr_carry_in = transfer & ~auto_reload;
    bus.addr_up       = ~ctrl_q[2];
    bus.ctrl_out      = ctrl_q;
    bus.wc_out        = wc_q;
    bus.done          = done;
    bus.data_out      = data_out_q;
    bus.data_oe       = data_oe_q;
  end

endmodule

// File: tb/tb_am2940_ctrl.sv
// Self-checking bench for am2940_ctrl: directed test-plan steps followed by random
// traffic, all compared against a behavioural model of the register set.
module tb_am2940_ctrl;

  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic clk;
  logic res;

  am2940_ctrl_if #(.WIDTH(W)) bus ();

  am2940_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int en_seen = 0;
  int reinit_seen = 0;
  string phase = "init";

  // Behavioural model state.
  int m_ctrl, m_wc, m_init, m_dout;
  bit m_ok, m_doe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic bit model_done();
    int mode = m_ctrl & 3;
    if (mode == 0 || mode == 2) return m_wc == 1;
    // Increment mode ends when one step remains before reaching the initial value.
    if (mode == 1) return ((m_init - m_wc) & M) == 1;
    return 1'b0;
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input bit rn, input bit ie, input int ins, input int dn, input bit ce);
    int  mode;
    bit  xfer, e_done, e_load, e_reinit, e_en, reload;
    res          = rn;
    bus.instr_en = ie;
    bus.instr    = ins[2:0];
    bus.data_in  = dn[W-1:0];
    bus.cnt_en   = ce;

    mode     = m_ctrl & 3;
    xfer     = ce && m_ok && !ie;
    e_done   = model_done();
    reload   = xfer && mode == 2 && e_done;
    e_load   = ie && ins == 5;
    e_reinit = (ie && ins == 4) || reload;
    e_en     = xfer && !reload;

    @(negedge clk);
    chk("addr_load", bus.addr_load, e_load);
    chk("addr_reinit", bus.addr_reinit, e_reinit);
    chk("addr_enable", bus.addr_enable, e_en);
    chk("addr_carry_in", bus.addr_carry_in, e_en);
    chk("addr_up", bus.addr_up, ((m_ctrl >> 2) & 1) == 0);
    chk("done", bus.done, e_done);
    chk("ctrl_out", bus.ctrl_out, m_ctrl);
    chk("wc_out", bus.wc_out, m_wc);
    chk("data_out", bus.data_out, m_dout);
    chk("data_oe", bus.data_oe, m_doe);
    if (bus.addr_enable === 1'b1) en_seen++;
    if (bus.addr_reinit === 1'b1) reinit_seen++;

    @(posedge clk);
    if (!rn) begin
      m_ctrl = 0; m_wc = 0; m_init = 0; m_ok = 0; m_dout = 0; m_doe = 0;
    end else begin
      m_doe = 0;
      if (ie) begin
        case (ins)
          0: begin m_ctrl = dn & 7; m_ok = 0; end
          1: begin m_dout = m_ctrl; m_doe = 1; end
          2: begin m_dout = m_wc; m_doe = 1; end
          4: m_wc = (mode == 1) ? 0 : m_init;
          6: begin m_init = dn & M; m_wc = (mode == 1) ? 0 : (dn & M); m_ok = 0; end
          7: m_ok = 1;
          default: ;
        endcase
      end else if (xfer) begin
        case (mode)
          0: begin m_wc = (m_wc + M) & M; if (e_done) m_ok = 0; end
          1: begin m_wc = (m_wc + 1) & M; if (e_done) m_ok = 0; end
          2: m_wc = e_done ? m_init : ((m_wc + M) & M);
          default: ;
        endcase
      end
    end
    #1;
  endtask

  initial begin
    res          = 1'b0;
    bus.instr_en = 1'b0;
    bus.instr    = 3'b000;
    bus.data_in  = '0;
    bus.cnt_en   = 1'b0;
    m_ctrl = 0; m_wc = 0; m_init = 0; m_ok = 0; m_dout = 0; m_doe = 0;
    // Bring registers out of X before anything is compared.
    @(posedge clk);
    #1;

    phase = "reset";
    cyc(1, 1, 0, 7, 0);          // WRCR 7
    cyc(1, 1, 7, 0, 0);          // ENCT
    cyc(0, 1, 7, 0, 1);          // reset wins over ENCT and transfer
    cyc(1, 0, 3, 0, 1);          // cnt_ok must be 0: no transfer
    chk("rst_wc", bus.wc_out, 0);
    chk("rst_ctrl", bus.ctrl_out, 0);

    phase = "m00";
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 6, 3, 0);
    cyc(1, 1, 7, 0, 1);          // cnt_en in ENCT cycle ignored
    en_seen = 0;
    repeat (4) cyc(1, 0, 0, 0, 1);
    chk("en_cycles", en_seen, 3);
    chk("wc_final", bus.wc_out, 0);

    phase = "m01";
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 6, 4, 0);
    cyc(1, 1, 7, 0, 0);
    en_seen = 0;
    repeat (5) cyc(1, 0, 0, 0, 1);
    chk("en_cycles", en_seen, 4);
    chk("wc_final", bus.wc_out, 4);

    phase = "m10";
    cyc(1, 1, 0, 6, 0);
    cyc(1, 1, 6, 2, 0);
    cyc(1, 1, 7, 0, 0);
    en_seen = 0;
    reinit_seen = 0;
    repeat (5) cyc(1, 0, 0, 0, 1);
    chk("reinit_pulses", reinit_seen, 2);
    chk("en_cycles", en_seen, 3);
    chk("wc_final", bus.wc_out, 1);
    chk("addr_up", bus.addr_up, 0);

    phase = "rdwc";
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 6, 'h5A, 0);
    cyc(1, 1, 7, 0, 0);
    cyc(1, 1, 2, 0, 1);          // RDWC with cnt_en: no transfer
    chk("data_out", bus.data_out, 'h5A);
    chk("data_oe", bus.data_oe, 1);
    cyc(1, 0, 3, 0, 0);
    chk("data_oe_drop", bus.data_oe, 0);
    chk("wc_held", bus.wc_out, 'h5A);

    phase = "ldad";
    cyc(1, 1, 5, 0, 1);
    cyc(1, 1, 4, 0, 0);          // REINIT
    cyc(1, 1, 0, 5, 0);
    cyc(1, 1, 1, 0, 0);          // RDCR
    chk("rdcr", bus.data_out, 5);

    phase = "m11";
    cyc(1, 1, 0, 3, 0);
    cyc(1, 1, 6, 'h33, 0);
    cyc(1, 1, 7, 0, 0);
    en_seen = 0;
    repeat (10) cyc(1, 0, 0, 0, 1);
    chk("en_cycles", en_seen, 10);
    chk("wc_frozen", bus.wc_out, 'h33);
    chk("done_low", bus.done, 0);

    phase = "abort";
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 6, 10, 0);
    cyc(1, 1, 7, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 1);
    chk("abort_wc", bus.wc_out, 0);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      bit rn, ie, ce;
      int ins, dn;
      rn  = ($urandom_range(0, 99) >= 2);
      ie  = ($urandom_range(0, 99) < 25);
      ce  = ($urandom_range(0, 99) < 75);
      ins = $urandom_range(0, 7);
      dn  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, M);
      cyc(rn, ie, ins, dn, ce);
    end
    cyc(1, 0, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
